sync_fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream of the dual_port_ram block and drives its cs, wr_en, rd_en, wr_addr, rd_addr and wr_data. It converts a push/pop stream interface into RAM accesses using wrapping read and write pointers. It also maintains occupancy and full/empty/almost-full status and sticky error flags. RAM read data returns through the controller as pop_data, qualified by pop_valid.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/dual_port_ram.sv | 31 +++
 rtl/sync_fifo_top.sv | 73 +++++++
 rtl/sync_fifo_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and defaults for the synchronous FIFO controller and its RAM.
// Keeping them in one place makes the RAM and the controller agree on sizes.
package fifo_pkg;

  localparam int FIFO_DATA_W   = 8;
  localparam int FIFO_ADDR_W   = 4;
  localparam int FIFO_DEPTH    = 2 ** FIFO_ADDR_W;
  localparam int FIFO_CNT_W    = FIFO_ADDR_W + 1;
  localparam int FIFO_AF_LEVEL = 14;

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
// Read data appears one cycle after an enabled read.
module dual_port_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              cs,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately never cleared; only the controller state resets.
  always_ff @(posedge clk) begin
    if (cs && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (cs && rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_top.sv
// Thin wrapper pairing the FIFO controller with its dual-port RAM.
module sync_fifo_top
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  logic              ram_cs;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  sync_fifo_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF_LEVEL)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_cs      (ram_cs),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  dual_port_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .cs      (ram_cs),
    .wr_en   (ram_wr_en),
    .rd_en   (ram_rd_en),
    .wr_addr (ram_wr_addr),
    .rd_addr (ram_rd_addr),
    .wr_data (ram_wr_data),
    .rd_data (ram_rd_data)
  );

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FIFO controller: turns a push/pop stream into RAM accesses with wrapping
// pointers, and tracks occupancy, status flags and sticky error flags.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_cs,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_THRESH  = (ADDR_W + 1)'(AF_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full        = (count == FULL_LEVEL);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_THRESH);

  // Reset gates the accept terms so no RAM access can leak out during reset.
  assign push_ok = push && !full && !reset;
  assign pop_ok  = pop && !empty && !reset;

  assign ram_wr_en   = push_ok;
  assign ram_rd_en   = pop_ok;
  assign ram_cs      = push_ok || pop_ok;
  assign ram_wr_addr = wr_ptr;
  assign ram_rd_addr = rd_ptr;
  assign ram_wr_data = push_data;
  assign pop_data    = ram_rd_data;

  // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (ADDR_W + 1)'(1);
      end else if (!push_ok && pop_ok) begin
        count <= count - (ADDR_W + 1)'(1);
      end
      pop_valid <= pop_ok;
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
